// File: rtl/block_token_emitter_if.sv
// block_token_emitter_if: command and byte-stream handshakes of the token emitter
// BLOCK_EMIT_UPPER_EN adds cmd_upper to the command side.
interface block_token_emitter_if;
  logic cmd_valid;
  logic cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_char;
  logic out_valid;
  logic out_ready;
  logic [7:0] out_char;
`ifdef BLOCK_EMIT_UPPER_EN
  logic cmd_upper;
  modport master(output cmd_valid, cmd_op, cmd_char, cmd_upper, out_ready, input cmd_ready, out_valid, out_char);
  modport slave(input cmd_valid, cmd_op, cmd_char, cmd_upper, out_ready, output cmd_ready, out_valid, out_char);
`else
  modport master(output cmd_valid, cmd_op, cmd_char, out_ready, input cmd_ready, out_valid, out_char);
  modport slave(input cmd_valid, cmd_op, cmd_char, out_ready, output cmd_ready, out_valid, out_char);
`endif
endinterface

// File: rtl/block_token_emitter.sv
// block_token_emitter: serialises BEGIN/END/WORD/SPACE tokens as ASCII bytes plus a trailing space, tracking nesting depth
// BLOCK_EMIT_UPPER_EN enables cmd_upper for uppercase BEGIN/END keywords.
module block_token_emitter #(
  parameter int DEPTH_W = 8
) (
  input  logic clk,
  input  logic reset,
  block_token_emitter_if.slave bus,
  output logic [DEPTH_W-1:0] depth,
  output logic balanced,
  output logic err_underflow,
  output logic err_overflow
);
  typedef enum logic [1:0] {IDLE, EMIT, SEP} state_t;
  localparam logic [1:0] OP_BEGIN = 2'd0, OP_END = 2'd1, OP_WORD = 2'd2, OP_SPACE = 2'd3;
  state_t state;
  logic [39:0] sreg, tok;
  logic [2:0] cnt;
  logic up, accept, sep_only;
`ifdef BLOCK_EMIT_UPPER_EN
  assign up = bus.cmd_upper;
`else
  assign up = 1'b0;
`endif
  assign bus.cmd_ready = state == IDLE && reset;
  assign accept = bus.cmd_valid && bus.cmd_ready;
  assign sep_only = bus.cmd_op == OP_SPACE || (bus.cmd_op == OP_WORD && bus.cmd_char == 8'h20);
  assign balanced = depth == '0 && !err_underflow && !err_overflow;
  // Token bytes left-aligned; clearing bit 5 of each letter uppercases keywords.
  always_comb begin
    tok = bus.cmd_op == OP_BEGIN ? "begin" : bus.cmd_op == OP_END ? {"end", 16'h0} : {bus.cmd_char, 32'h0};
    tok = up && !bus.cmd_op[1] ? tok & {5{8'hdf}} : tok;
  end
  always_ff @(posedge clk)
    if (!reset) begin
      state <= IDLE;
      sreg <= '0;
      cnt <= '0;
      bus.out_valid <= 1'b0;
      bus.out_char <= 8'h00;
      depth <= '0;
      err_underflow <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          state <= sep_only ? SEP : EMIT;
          sreg <= tok;
          cnt <= bus.cmd_op == OP_BEGIN ? 3'd4 : bus.cmd_op == OP_END ? 3'd2 : 3'd0;
          bus.out_valid <= 1'b1;
          bus.out_char <= sep_only ? 8'h20 : tok[39:32];
          depth <= bus.cmd_op == OP_BEGIN ? (&depth ? depth : depth + 1'b1) :
                   bus.cmd_op == OP_END ? (depth == '0 ? depth : depth - 1'b1) : depth;
          err_overflow <= err_overflow || (bus.cmd_op == OP_BEGIN && &depth);
          err_underflow <= err_underflow || (bus.cmd_op == OP_END && depth == '0);
        end
        EMIT: if (bus.out_ready) begin
          state <= cnt == '0 ? SEP : EMIT;
          cnt <= cnt - 1'b1;
          sreg <= sreg << 8;
          bus.out_char <= cnt == '0 ? 8'h20 : sreg[31:24];
        end
        SEP: if (bus.out_ready) begin
          state <= IDLE;
          bus.out_valid <= 1'b0;
          bus.out_char <= 8'h00;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: doc/block_token_emitter.md
Name: block_token_emitter

Overview:
- Transmit-side counterpart of the begin/end block checker.
- Accepts token commands (BEGIN, END, WORD, SPACE) on a valid/ready command port.
- Serialises each token as lowercase ASCII, one byte per accepted output beat, followed by a single space (0x20). Output uses valid/ready handshake.
- Tracks nesting depth so the producer knows when the emitted stream is balanced; feeds the checker and bench stimulus paths.

Parameters:
DEPTH_W, 8, width of the nesting-depth counter; depth saturates at 2^DEPTH_W-1

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-low reset (reset==0 clears state at next clk rising edge)
cmd_valid  input  1  command present
cmd_op  input  2  0=BEGIN, 1=END, 2=WORD, 3=SPACE
cmd_char  input  8  character for WORD; ignored otherwise
cmd_ready  output  1  emitter can accept a command
out_ready  input  1  downstream accepts out_char this cycle
out_valid  output  1  out_char valid
out_char  output  8  emitted ASCII byte
depth  output  DEPTH_W  current open-block count
balanced  output  1  depth==0 and no error flag set
err_underflow  output  1  sticky: END accepted while depth==0
err_overflow  output  1  sticky: BEGIN accepted while depth saturated

Behaviour:
- Reset values: cmd_ready=0 during reset, 1 in the first cycle after reset releases. out_valid=0, out_char=8'h00, depth=0, balanced=1, err_*=0, FSM=IDLE.
- FSM states: IDLE, EMIT, SEP.
  - IDLE: cmd_ready=1, out_valid=0. On cmd_valid&&cmd_ready: latch token, go to EMIT (SPACE op goes directly to SEP).
  - EMIT: out_valid=1, out_char=token[idx]. Beat completes on out_valid&&out_ready: idx++. After the last byte, go to SEP.
  - SEP: out_valid=1, out_char=0x20. On out_ready go to IDLE.
- Tokens:
  - BEGIN emits "b","e","g","i","n".
  - END emits "e","n","d".
  - WORD emits cmd_char (1 byte). WORD with cmd_char==0x20 behaves as SPACE.
  - SPACE emits only the separator.
- Latency: first byte is valid in the cycle after command acceptance. Back-to-back commands add no extra bubble beyond the IDLE accept cycle.
  - BEGIN: 7 cycles accept-to-accept with out_ready held at 1.
  - END: 5 cycles, same condition.
  - WORD: 3 cycles, same condition.
- Backpressure: while out_valid=1 and out_ready=0, out_char and idx hold stable. cmd_ready stays 0 outside IDLE.
- Depth update occurs in the accept cycle, not after emission.
  - BEGIN: depth+1. If depth==max, depth holds and err_overflow sets.
  - END: depth-1. If depth==0, depth holds at 0 and err_underflow sets. The token is still emitted.
- Error flags are sticky until reset. balanced is combinational from depth and both flags.
- Reset asserted mid-token: emission aborts immediately. No partial token is completed; all state returns to reset values.
- cmd_op/cmd_char are sampled only on acceptance; changes while cmd_ready=0 are ignored.

Optional Feature:
- Macro: BLOCK_EMIT_UPPER_EN.
- Defined: adds input cmd_upper (1 bit), latched with the command. When it is 1, BEGIN/END letters are emitted uppercase ("BEGIN", "END"); WORD is passed unchanged. This exercises the checker's case folding.
- Undefined: no cmd_upper port; all BEGIN/END output is lowercase.

Test Plan:
- Reset low 2 cycles, then high -> out_valid=0, depth=0, balanced=1, cmd_ready=1 in first post-reset cycle.
- BEGIN, WORD 'x', END with out_ready=1 -> byte stream 62 65 67 69 6E 20 78 20 65 6E 64 20.
  - depth sequence 1,1,0; balanced=1 at end.
- BEGIN with out_ready toggling 1,0,0,1,... -> out_char holds during stall; all 6 bytes emitted exactly once, in order.
- END at depth 0 -> "end " still emitted; err_underflow=1, depth=0, balanced=0; a following BEGIN/END pair leaves balanced=0.
- DEPTH_W=2: 4 BEGINs -> depth saturates at 3, err_overflow=1 on the 4th.
- Reset driven low during the 3rd byte of BEGIN -> next cycle out_valid=0, depth=0; a fresh END emits "end " and sets err_underflow.
